// File: rtl/uart_pkg.sv
// Shared types for the oversampled UART receiver: FSM state encoding and
// parity-mode selector values.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    localparam int unsigned NONE = 0;
    localparam int unsigned EVEN = 1;
    localparam int unsigned ODD  = 2;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input; both flops
// reset to RST_VAL so an idle-high line does not look like an edge.
module uart_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_os.sv
// Oversampled UART receiver: start-bit qualification at mid-bit, one sample
// per bit, optional parity, 1-2 stop bits, valid/ready output with overrun.
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_serial,
    input  logic                 os_tick,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun_err
);

    localparam int unsigned TW = $clog2(OVERSAMPLE);
    localparam int unsigned BW = $clog2(DATA_BITS);
    localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_FULL = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);
    localparam logic          ODD_P     = (PARITY == ODD);

    state_t               state;
    logic                 rx_s;
    logic                 rx_prev;
    logic [TW-1:0]        tick_cnt;
    logic [BW-1:0]        bit_idx;
    logic                 stop_idx;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 par_pend;
    logic                 frm_pend;
    logic                 done;
    logic                 sample;

    uart_sync2 #(.RST_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx_serial),
        .q   (rx_s)
    );

    always_comb begin
        sample = os_tick && (tick_cnt == TICK_FULL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            rx_prev     <= 1'b1;
            tick_cnt    <= '0;
            bit_idx     <= '0;
            stop_idx    <= 1'b0;
            shift_reg   <= '0;
            par_pend    <= 1'b0;
            frm_pend    <= 1'b0;
            done        <= 1'b0;
            data_out    <= '0;
            data_valid  <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            rx_prev     <= rx_s;
            done        <= 1'b0;
            overrun_err <= 1'b0;

            // Handshake and completion in the same clk: the load below wins.
            if (data_valid && data_ready)
                data_valid <= 1'b0;
            if (done) begin
                if (!data_valid || data_ready) begin
                    data_out   <= shift_reg;
                    parity_err <= par_pend;
                    frame_err  <= frm_pend;
                    data_valid <= 1'b1;
                end else begin
                    overrun_err <= 1'b1;
                end
            end

            if (os_tick && state != ST_IDLE)
                tick_cnt <= tick_cnt + 1'b1;

            case (state)
                ST_IDLE: begin
                    if (rx_prev && !rx_s) begin
                        state    <= ST_START;
                        tick_cnt <= '0;
                        par_pend <= 1'b0;
                        frm_pend <= 1'b0;
                    end
                end
                ST_START: begin
                    if (os_tick && tick_cnt == TICK_HALF) begin
                        tick_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= rx_s ? ST_IDLE : ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (sample) begin
                        tick_cnt           <= '0;
                        shift_reg[bit_idx] <= rx_s;
                        if (bit_idx == LAST_BIT) begin
                            stop_idx <= 1'b0;
                            state    <= (PARITY != NONE) ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (sample) begin
                        tick_cnt <= '0;
                        if (rx_s != ((^shift_reg) ^ ODD_P))
                            par_pend <= 1'b1;
                        stop_idx <= 1'b0;
                        state    <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (sample) begin
                        tick_cnt <= '0;
                        if (!rx_s)
                            frm_pend <= 1'b1;
                        if (stop_idx == STOP_LAST) begin
                            state <= ST_IDLE;
                            done  <= 1'b1;
                        end else begin
                            stop_idx <= 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed test of uart_rx_os at 8 data bits, even parity, 1 stop bit,
// 16x oversampling with one os_tick every 4 clks (64 clks per bit).
module tb_uart_rx_os;

    localparam int BIT_CLKS = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_serial = 1'b1;
    logic       os_tick = 1'b0;
    logic [7:0] data_out;
    logic       data_valid;
    logic       data_ready = 1'b1;
    logic       parity_err;
    logic       frame_err;
    logic       overrun_err;

    int errors = 0;
    int checks = 0;

    int         vclk_cnt = 0;
    int         ovr_cnt  = 0;
    logic [7:0] cap_data = '0;
    logic       cap_pe   = 1'b0;
    logic       cap_fe   = 1'b0;
    int         v0, o0;

    uart_rx_os #(
        .DATA_BITS (8),
        .PARITY    (1),
        .STOP_BITS (1),
        .OVERSAMPLE(16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_serial  (rx_serial),
        .os_tick    (os_tick),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overrun_err(overrun_err)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            repeat (3) @(posedge clk);
            #1 os_tick = 1'b1;
            @(posedge clk);
            #1 os_tick = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (data_valid) begin
            vclk_cnt = vclk_cnt + 1;
            cap_data = data_out;
            cap_pe   = parity_err;
            cap_fe   = frame_err;
        end
        if (overrun_err)
            ovr_cnt = ovr_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        if (obs !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        rx_serial = b;
        repeat (BIT_CLKS) @(posedge clk);
        #1;
    endtask

    task automatic idle_bits(input int n);
        rx_serial = 1'b1;
        repeat (n * BIT_CLKS) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stp);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++)
            send_bit(d[i]);
        send_bit(par);
        send_bit(stp);
    endtask

    initial begin
        repeat (4) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_valid",   32'(data_valid),  32'd0);
        check("rst_data",    32'(data_out),    32'd0);
        check("rst_perr",    32'(parity_err),  32'd0);
        check("rst_ferr",    32'(frame_err),   32'd0);
        check("rst_overrun", 32'(overrun_err), 32'd0);
        idle_bits(1);

        // 0xA5 has four ones, so even parity bit is 0
        v0 = vclk_cnt;
        send_frame(8'hA5, 1'b0, 1'b1);
        idle_bits(2);
        check("a5_valid_clks", 32'(vclk_cnt - v0), 32'd1);
        check("a5_data",       32'(cap_data),      32'hA5);
        check("a5_perr",       32'(cap_pe),        32'd0);
        check("a5_ferr",       32'(cap_fe),        32'd0);

        v0 = vclk_cnt;
        send_frame(8'hA5, 1'b1, 1'b1);
        idle_bits(2);
        check("a5p_valid_clks", 32'(vclk_cnt - v0), 32'd1);
        check("a5p_data",       32'(cap_data),      32'hA5);
        check("a5p_perr",       32'(cap_pe),        32'd1);
        check("a5p_ferr",       32'(cap_fe),        32'd0);

        // Stop bit low, then line stuck low for 20 bit times
        v0 = vclk_cnt;
        send_frame(8'h3C, 1'b0, 1'b0);
        rx_serial = 1'b0;
        repeat (20 * BIT_CLKS) @(posedge clk);
        #1;
        check("3c_valid_clks", 32'(vclk_cnt - v0), 32'd1);
        check("3c_data",       32'(cap_data),      32'h3C);
        check("3c_ferr",       32'(cap_fe),        32'd1);
        idle_bits(2);
        check("3c_no_retrigger", 32'(vclk_cnt - v0), 32'd1);
        v0 = vclk_cnt;
        send_frame(8'h81, 1'b0, 1'b1);
        idle_bits(2);
        check("81_valid_clks", 32'(vclk_cnt - v0), 32'd1);
        check("81_data",       32'(cap_data),      32'h81);
        check("81_ferr",       32'(cap_fe),        32'd0);

        // Low glitch of 4 os_ticks is a false start
        v0 = vclk_cnt;
        rx_serial = 1'b0;
        repeat (16) @(posedge clk);
        #1;
        idle_bits(2);
        check("glitch_no_valid", 32'(vclk_cnt - v0), 32'd0);
        send_frame(8'h0F, 1'b0, 1'b1);
        idle_bits(2);
        check("post_glitch_clks", 32'(vclk_cnt - v0), 32'd1);
        check("post_glitch_data", 32'(cap_data),      32'h0F);
        check("post_glitch_perr", 32'(cap_pe),        32'd0);

        // Overrun: consumer stalled across two frames
        data_ready = 1'b0;
        o0 = ovr_cnt;
        send_frame(8'h11, 1'b0, 1'b1);
        idle_bits(1);
        @(negedge clk);
        check("ovr_first_valid", 32'(data_valid), 32'd1);
        check("ovr_first_data",  32'(data_out),   32'h11);
        send_frame(8'h22, 1'b0, 1'b1);
        idle_bits(1);
        @(negedge clk);
        check("ovr_hold_data",  32'(data_out),      32'h11);
        check("ovr_hold_valid", 32'(data_valid),    32'd1);
        check("ovr_pulses",     32'(ovr_cnt - o0),  32'd1);
        data_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("ovr_consumed", 32'(data_valid), 32'd0);
        idle_bits(1);

        // Reset during data bit 3 of 0x5A
        v0 = vclk_cnt;
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        rx_serial = 1'b1;
        repeat (BIT_CLKS / 2) @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("mid_rst_valid",   32'(data_valid),  32'd0);
        check("mid_rst_data",    32'(data_out),    32'd0);
        check("mid_rst_perr",    32'(parity_err),  32'd0);
        check("mid_rst_ferr",    32'(frame_err),   32'd0);
        check("mid_rst_overrun", 32'(overrun_err), 32'd0);
        idle_bits(2);
        check("mid_rst_no_output", 32'(vclk_cnt - v0), 32'd0);
        send_frame(8'h5A, 1'b0, 1'b1);
        idle_bits(2);
        check("5a_valid_clks", 32'(vclk_cnt - v0), 32'd1);
        check("5a_data",       32'(cap_data),      32'h5A);
        check("5a_perr",       32'(cap_pe),        32'd0);
        check("5a_ferr",       32'(cap_fe),        32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_os.md
UART_RX_OS -- requirements
Module: uart_rx_os

Interface
REQ-001 Parameter DATA_BITS, default 8, data bits per frame, legal range 5..9.
REQ-002 Parameter PARITY, default 0, parity mode: 0 none, 1 even, 2 odd.
REQ-003 Parameter STOP_BITS, default 1, stop bits per frame, legal values 1 or 2.
REQ-004 Parameter OVERSAMPLE, default 16, os_tick pulses per bit period, even, legal range 8..32.
REQ-005 clk  input  1  single clock; all logic SHALL be clocked on its rising edge.
REQ-006 rst  input  1  reset; synchronous and active-high.
REQ-007 rx_serial  input  1  asynchronous serial line, idle high, LSB-first frames.
REQ-008 os_tick  input  1  one-clk pulse at OVERSAMPLE x baud rate.
REQ-009 data_out  output  DATA_BITS  received word, held while data_valid is high.
REQ-010 data_valid  output  1  data_out, parity_err and frame_err are valid.
REQ-011 data_ready  input  1  consumer accepts the word when data_valid && data_ready.
REQ-012 parity_err  output  1  parity mismatch in the held word; always 0 when PARITY=0.
REQ-013 frame_err  output  1  a stop bit of the held word sampled low.
REQ-014 overrun_err  output  1  one-clk pulse when a completed frame is dropped.

Function
REQ-015 rx_serial SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value (rx_s).
REQ-016 FSM states: IDLE, START, DATA, PARITY, STOP.
REQ-017 IDLE->START only on a falling edge of rx_s (previous high, current low); a line held low never re-triggers.
REQ-018 START: count OVERSAMPLE/2 os_ticks, then sample rx_s; low -> DATA with tick counter cleared; high -> false start, back to IDLE, no output.
REQ-019 DATA/PARITY/STOP: each bit sampled once, on the OVERSAMPLE-th os_tick after the previous sample (mid-bit).
REQ-020 DATA: bit n is stored to shift position n, LSB first; after bit DATA_BITS-1 go to PARITY if PARITY!=0, else to STOP.
REQ-021 PARITY: sampled bit compared against the XOR of the data bits (even) or its inverse (odd); mismatch sets a pending parity flag.
REQ-022 STOP: STOP_BITS samples; any low sample sets a pending frame flag; after the last sample go to IDLE on the same clk.
REQ-023 Frame completion: on the clk after the last stop sample, data_valid=1 and data_out plus both error flags are loaded; frames with errors are delivered, not dropped.
REQ-024 data_valid clears on the clk after data_valid && data_ready.
REQ-025 At completion with data_valid=1 and data_ready=0: the new frame is discarded, old outputs are held, and overrun_err pulses for 1 clk.
REQ-026 Completion in the same clk as a handshake: the new frame is loaded, data_valid stays 1, no overrun.
REQ-027 Ticks are counted only on os_tick; the FSM holds state between ticks; back-to-back frames with no idle gap SHALL be received.
REQ-028 Tick counter width is $clog2(OVERSAMPLE); bit index width is $clog2(DATA_BITS); counters never wrap mid-bit.

Reset
REQ-029 rst SHALL force IDLE; clear data_out, data_valid, parity_err, frame_err, overrun_err and all counters to 0; and load the synchronizer and edge registers to 1.
REQ-030 rst mid-frame SHALL abandon the frame with no output; the next falling edge starts a fresh frame.

Structure
REQ-031 Package uart_pkg SHALL hold the state enum and the parity-mode constants NONE/EVEN/ODD.
REQ-032 Sub-module uart_sync2: 2-flop synchronizer with parameterised reset value, instantiated once.

Verification
REQ-033 Settings: OVERSAMPLE=16, DATA_BITS=8, PARITY=1, STOP_BITS=1, data_ready=1. Send 0xA5 with parity 0 -> data_out=0xA5, data_valid high for 1 clk, all errors 0.
REQ-034 Send 0xA5 with parity bit 1 -> data_out=0xA5 with parity_err=1 and frame_err=0.
REQ-035 Send 0x3C with stop bit low, then hold the line low for 20 bit times -> one word with frame_err=1 and no further data_valid until the line returns high and falls again.
REQ-036 Drive a low glitch of 4 os_ticks -> no data_valid; the FSM returns to IDLE.
REQ-037 With data_ready=0, send 0x11 then 0x22 -> data_out holds 0x11 and overrun_err pulses once; raising data_ready consumes 0x11.
REQ-038 Assert rst during DATA bit 3 -> all outputs 0; a following 0x5A is received correctly.
